muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/md_shift_core.sv | 65 ++++++
 rtl/muldiv_ctrl.sv | 101 ++++++++++
 tb/tb_muldiv_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encodings and small decode helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULH = 2'b01,
    MD_DIVU = 2'b10,
    MD_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  // Bit 1 of the op code separates divide-class from multiply-class.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Bit 0 selects the upper register of the pair (MULH high half, REMU remainder).
  function automatic logic md_sel_hi(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/md_shift_core.sv
// Accumulator/shift datapath for one-bit-per-cycle multiply and restoring divide.
// The register pair {hi, lo} holds the product (mul) or {remainder, quotient}
// (div). The next-step values are exported combinationally so the controller
// can capture the final result on the same edge as the last iteration.
module md_shift_core
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One iteration: shift-add for multiply, shift-compare-subtract for divide.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operand capture on load, one iteration per step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MUL/MULH/DIVU/REMU controller for the EX stage.
//
// Handshake: EX raises start with op/operands while the unit is IDLE; the
// request is accepted on that edge unless flush is also high. stall is high
// from the accepting cycle through the last CALC cycle and low in DONE, so the
// pipeline advances exactly in the cycle where done pulses and result is valid.
// flush or reset abandon any operation with no done pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e        state;
  md_op_e           op_q;
  logic [CW-1:0]    count;
  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign accept = (state == S_IDLE) && start && !flush;
  assign b_zero = (operand_b == '0);

  // Outputs decoded from state; stall also covers the accepting IDLE cycle.
  assign stall = accept || (state == S_CALC);
  assign busy  = (state == S_CALC) || (state == S_DONE);
  assign done  = (state == S_DONE);

  md_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step    ((state == S_CALC) && !flush),
    .is_div  (md_is_div(op)),
    .a       (operand_a),
    .b       (operand_b),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Control FSM: accept, iterate ITER times, publish result for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= MD_MUL;
      count    <= '0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= md_op_e'(op);
            count    <= CW'(ITER - 1);
            div_zero <= md_is_div(op) && b_zero;
            if (md_is_div(op) && b_zero) begin
              // Divide by zero: all-ones quotient, dividend as remainder.
              result <= (op == MD_DIVU) ? '1 : operand_a;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          count <= count - CW'(1);
          if (count == '0) begin
            result <= md_sel_hi(op_q) ? hi_next : lo_next;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl with hand-computed expected values.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_zero;

  int n_checks;
  int n_fail;

  muldiv_ctrl #(.WIDTH(16), .ITER(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .div_zero  (div_zero)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle (cycle 0), then scramble the operands.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    check("stall_c0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start     = 1'b0;
    operand_a = 16'($urandom);
    operand_b = 16'($urandom_range(0, 65535));
  endtask

  // Wait for done; lat is the cycle index after the start cycle, -1 on timeout.
  task automatic wait_done(input int max_cyc, output int lat, output logic stall_ok);
    lat = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (stall !== ~done) stall_ok = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int   lat;
    logic sok;
    issue(o, a, b);
    wait_done(40, lat, sok);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall"}, {31'd0, sok}, 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    @(negedge clk);
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic sok;
    logic nodone;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6",     MD_MUL,  16'h0007, 16'h0006, 16'h002A, 1'b0, 17);
    run_op("mulh_ffff",   MD_MULH, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);
    run_op("mul_ffff",    MD_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17);
    run_op("divu_100_7",  MD_DIVU, 16'd100,  16'd7,    16'h000E, 1'b0, 17);
    run_op("remu_100_7",  MD_REMU, 16'd100,  16'd7,    16'h0002, 1'b0, 17);
    run_op("divu_zero",   MD_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1);
    run_op("remu_zero",   MD_REMU, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1);
    run_op("divu_dz_clr", MD_DIVU, 16'd1000, 16'd3,    16'd333,  1'b0, 17);
    run_op("remu_1000_3", MD_REMU, 16'd1000, 16'd3,    16'd1,    1'b0, 17);

    // start held high through CALC and DONE: no restart, no accept in DONE
    @(posedge clk); #1;
    start = 1'b1; op = MD_MUL; operand_a = 16'h0007; operand_b = 16'h0006;
    @(posedge clk); #1;
    operand_a = 16'h1111; operand_b = 16'h2222;
    wait_done(40, lat, sok);
    check("hold_latency", 32'(lat), 32'd17);
    check("hold_stall", {31'd0, sok}, 32'd1);
    check("hold_result", {16'd0, result}, 32'h002A);
    @(negedge clk);
    check("hold_no_accept_in_done", {31'd0, busy}, 32'd0);
    check("hold_idle_stall", {31'd0, stall}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("hold_released", {31'd0, busy}, 32'd0);

    // flush in cycle 5 of a MUL, new start accepted in cycle 6
    issue(MD_MUL, 16'h0003, 16'h0005);
    nodone = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0) nodone = 1'b0;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) nodone = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b1; op = MD_MUL; operand_a = 16'h0009; operand_b = 16'h0009;
    @(negedge clk);
    check("flush_no_done", {31'd0, nodone}, 32'd1);
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("flush_done_low", {31'd0, done}, 32'd0);
    check("flush_result_kept", {16'd0, result}, 32'h002A);
    check("flush_restart_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, lat, sok);
    check("flush_restart_latency", 32'(lat), 32'd17);
    check("flush_restart_result", {16'd0, result}, 32'h0051);

    // reset in cycle 8 of a DIVU
    issue(MD_DIVU, 16'd1000, 16'd7);
    for (int c = 1; c <= 7; c++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);
    check("mid_rst_div_zero", {31'd0, div_zero}, 32'd0);
    nodone = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) nodone = 1'b0;
    end
    check("mid_rst_no_done", {31'd0, nodone}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
